mux2_rr_arbiter: RTL

- Shares one N-bit output path between two requesters (A, B) using round-robin priority.
- Drives the 2:1 select and captures the winning word into a single-entry output register.
- Downstream side uses a valid/ready handshake.
- Sits in front of any single-consumer datapath that needs two producers feeding a shared mux.

---
 rtl/mux2_arb_pkg.sv | 15 +
 rtl/mux2_rr_pick.sv | 24 ++
 rtl/mux2_rr_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Counter width is only used when MUX2_ARB_GRANT_CNT_EN is defined.
package mux2_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux2_rr_pick.sv
// Combinational round-robin pick between two requesters.
// On contention the requester opposite to the last winner is chosen.
module mux2_rr_pick
  import mux2_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic pick,
  output logic any
);

  always_comb begin
    pick = SEL_A;
    if (req_a && req_b) begin
      pick = ~last;
    end else if (req_b) begin
      pick = SEL_B;
    end
  end

  assign any = req_a | req_b;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry valid/ready output register.
// Define MUX2_ARB_GRANT_CNT_EN to add saturating per-requester grant counters.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [N-1:0]     a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [N-1:0]     b,
  output logic             gnt_b,
  output logic [N-1:0]     y,
  output logic             y_valid,
  input  logic             y_ready,
`ifdef MUX2_ARB_GRANT_CNT_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  output logic             s
);

  state_t       state_reg;
  logic         last_reg;
  logic         s_reg;
  logic [N-1:0] y_reg;
  logic         accept;
  logic         pick;
  logic         any;
  logic         grant;

  mux2_rr_pick u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last_reg),
    .pick  (pick),
    .any   (any)
  );

  // A stalled FULL register blocks all grants so y and s stay stable.
  assign accept = (state_reg == EMPTY) | y_ready;
  assign gnt_a  = accept & any & (pick == SEL_A) & req_a;
  assign gnt_b  = accept & any & (pick == SEL_B) & req_b;
  assign grant  = gnt_a | gnt_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
      last_reg  <= SEL_B;
      s_reg     <= SEL_A;
      y_reg     <= '0;
    end else if (grant) begin
      state_reg <= FULL;
      last_reg  <= pick;
      s_reg     <= pick;
      y_reg     <= (pick == SEL_B) ? b : a;
    end else if (accept) begin
      state_reg <= EMPTY;
    end
  end

  assign y       = y_reg;
  assign s       = s_reg;
  assign y_valid = (state_reg == FULL);

`ifdef MUX2_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_a_reg;
  logic [CNT_W-1:0] cnt_b_reg;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else begin
      if (gnt_a && (cnt_a_reg != {CNT_W{1'b1}})) begin
        cnt_a_reg <= cnt_a_reg + 1'b1;
      end
      if (gnt_b && (cnt_b_reg != {CNT_W{1'b1}})) begin
        cnt_b_reg <= cnt_b_reg + 1'b1;
      end
    end
  end

  assign cnt_a = cnt_a_reg;
  assign cnt_b = cnt_b_reg;
`endif

endmodule
